// File: rtl/key_search_scheduler.sv
// key_search_scheduler: dispatches keys 0..KEY_MAX to a bank of decryption
// cores over a start/done/ack handshake, stops on the first successful key,
// drains in-flight cores and reports the result.
// Optional build macro SCHED_ABORT_EN adds the search_abort input.
module key_search_scheduler #(
   parameter int unsigned N_CORES = 4,
   parameter int unsigned KEY_W   = 10,
   parameter int unsigned KEY_MAX = (1 << KEY_W) - 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       search_start,
`ifdef SCHED_ABORT_EN
   input  logic                       search_abort,
`endif
   output logic                       search_busy,
   output logic                       search_done,
   output logic                       key_found,
   output logic [KEY_W-1:0]           found_key,
   output logic [KEY_W:0]             keys_tried,
   output logic [N_CORES-1:0]         core_start,
   output logic [N_CORES*KEY_W-1:0]   core_key,
   input  logic [N_CORES-1:0]         core_done,
   input  logic [N_CORES-1:0]         core_found,
   output logic [N_CORES-1:0]         core_ack
);

   localparam int unsigned CNT_W = KEY_W + 1;
   localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_MAX);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]               state_q, state_d;
   logic [CNT_W-1:0]         next_key_q, next_key_d;
   logic [N_CORES-1:0]       busy_q, busy_d;
   logic [N_CORES*KEY_W-1:0] core_key_q, core_key_d;
   logic [N_CORES-1:0]       core_start_q, core_start_d;
   logic [N_CORES-1:0]       core_ack_q, core_ack_d;
   logic [CNT_W-1:0]         keys_tried_q, keys_tried_d;
   logic                     key_found_q, key_found_d;
   logic [KEY_W-1:0]         found_key_q, found_key_d;
   logic                     search_busy_q, search_busy_d;
   logic                     search_done_q, search_done_d;

   logic                     abort_c;
   logic                     start_ok_c;
   logic [N_CORES-1:0]       ack_c;
   logic [CNT_W-1:0]         ack_cnt_c;
   logic                     find_c;
   logic [KEY_W-1:0]         win_key_c;
   logic                     picked_c;

   // Abort only matters while dispatching
`ifdef SCHED_ABORT_EN
   assign abort_c = search_abort && (state_q == S_RUN);
`else
   assign abort_c = 1'b0;
`endif

   // Next-state, dispatch, collection and result latching
   always_comb begin
      state_d       = state_q;
      next_key_d    = next_key_q;
      busy_d        = busy_q;
      core_key_d    = core_key_q;
      core_start_d  = '0;
      core_ack_d    = '0;
      keys_tried_d  = keys_tried_q;
      key_found_d   = key_found_q;
      found_key_d   = found_key_q;
      ack_c         = '0;
      ack_cnt_c     = '0;
      find_c        = 1'b0;
      win_key_c     = '0;
      picked_c      = 1'b0;
      start_ok_c    = search_start && ((state_q == S_IDLE) || (state_q == S_DONE));

      // Collect verdicts from every busy core reporting done
      if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
         for (int i = 0; i < int'(N_CORES); i++) begin
            if (core_done[i] && busy_q[i]) begin
               ack_c[i]  = 1'b1;
               ack_cnt_c = ack_cnt_c + CNT_W'(1);
            end
         end
      end

      // Descending scan so the lowest-index find is the one kept
      for (int i = int'(N_CORES) - 1; i >= 0; i--) begin
         if (ack_c[i] && core_found[i]) begin
            find_c    = 1'b1;
            win_key_c = core_key_q[i*KEY_W +: KEY_W];
         end
      end

      busy_d       = busy_q & ~ack_c;
      core_ack_d   = ack_c;
      keys_tried_d = keys_tried_q + ack_cnt_c;

      if (find_c && !key_found_q) begin
         key_found_d = 1'b1;
         found_key_d = win_key_c;
      end

      // Hand the next key to the lowest-index idle core
      if ((state_q == S_RUN) && (next_key_q <= KEY_LAST) && !find_c && !abort_c) begin
         for (int i = 0; i < int'(N_CORES); i++) begin
            if (!picked_c && !busy_q[i] && !core_done[i]) begin
               picked_c                      = 1'b1;
               core_start_d[i]               = 1'b1;
               busy_d[i]                     = 1'b1;
               core_key_d[i*KEY_W +: KEY_W]  = next_key_q[KEY_W-1:0];
               next_key_d                    = next_key_q + CNT_W'(1);
            end
         end
      end

      case (state_q)
         S_IDLE:  if (search_start) state_d = S_RUN;
         S_RUN:   if (find_c || abort_c || (next_key_q > KEY_LAST)) state_d = S_DRAIN;
         S_DRAIN: if (busy_q == '0) state_d = S_DONE;
         S_DONE:  if (search_start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase

      // A new sweep starts from a clean slate
      if (start_ok_c) begin
         key_found_d  = 1'b0;
         found_key_d  = '0;
         keys_tried_d = '0;
         next_key_d   = '0;
         busy_d       = '0;
      end

      search_busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
      search_done_d = (state_d == S_DONE);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         next_key_q    <= '0;
         busy_q        <= '0;
         core_key_q    <= '0;
         core_start_q  <= '0;
         core_ack_q    <= '0;
         keys_tried_q  <= '0;
         key_found_q   <= 1'b0;
         found_key_q   <= '0;
         search_busy_q <= 1'b0;
         search_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         next_key_q    <= next_key_d;
         busy_q        <= busy_d;
         core_key_q    <= core_key_d;
         core_start_q  <= core_start_d;
         core_ack_q    <= core_ack_d;
         keys_tried_q  <= keys_tried_d;
         key_found_q   <= key_found_d;
         found_key_q   <= found_key_d;
         search_busy_q <= search_busy_d;
         search_done_q <= search_done_d;
      end
   end

   assign search_busy = search_busy_q;
   assign search_done = search_done_q;
   assign key_found   = key_found_q;
   assign found_key   = found_key_q;
   assign keys_tried  = keys_tried_q;
   assign core_start  = core_start_q;
   assign core_key    = core_key_q;
   assign core_ack    = core_ack_q;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Directed bench for key_search_scheduler: 4 cores, 4-bit keys (0..15),
// behavioural cores with programmable latency, per-core hold and a find mask.
module tb_key_search_scheduler;

   localparam int unsigned NC = 4;
   localparam int unsigned KW = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              search_start;
   logic              search_abort;
   logic              search_busy;
   logic              search_done;
   logic              key_found;
   logic [KW-1:0]     found_key;
   logic [KW:0]       keys_tried;
   logic [NC-1:0]     core_start;
   logic [NC*KW-1:0]  core_key;
   logic [NC-1:0]     core_done;
   logic [NC-1:0]     core_found;
   logic [NC-1:0]     core_ack;

   int n_checks = 0;
   int n_errors = 0;

   // core model controls
   logic [NC-1:0] hold;
   logic [15:0]   find_mask;
   int            lat;
   int            cnt [NC];
   logic [KW-1:0] ckey [NC];

   // monitor state
   int            cyc = 0;
   int            n_starts = 0;
   int            n_acks = 0;
   int            last_start_cyc = 0;
   int            last_ack9_cyc = 0;
   int            log_core [256];
   int            log_key  [256];
   int            log_cyc  [256];
   int            disp_cnt [16];

   always #5 clk = ~clk;

   key_search_scheduler #(.N_CORES(NC), .KEY_W(KW), .KEY_MAX(15)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .search_start (search_start),
`ifdef SCHED_ABORT_EN
      .search_abort (search_abort),
`endif
      .search_busy  (search_busy),
      .search_done  (search_done),
      .key_found    (key_found),
      .found_key    (found_key),
      .keys_tried   (keys_tried),
      .core_start   (core_start),
      .core_key     (core_key),
      .core_done    (core_done),
      .core_found   (core_found),
      .core_ack     (core_ack)
   );

   // Behavioural decryption cores
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_done  <= '0;
         core_found <= '0;
         for (int i = 0; i < NC; i++) begin
            cnt[i]  <= 0;
            ckey[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NC; i++) begin
            if (core_start[i]) begin
               ckey[i] <= core_key[i*KW +: KW];
               cnt[i]  <= lat;
            end else if (cnt[i] > 1) begin
               cnt[i] <= cnt[i] - 1;
            end else if (cnt[i] == 1 && !hold[i]) begin
               cnt[i]        <= 0;
               core_done[i]  <= 1'b1;
               core_found[i] <= find_mask[ckey[i]];
            end
            if (core_done[i] && core_ack[i]) begin
               core_done[i]  <= 1'b0;
               core_found[i] <= 1'b0;
            end
         end
      end
   end

   // Dispatch / ack log, sampled mid-cycle
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (reset_n) begin
         for (int i = 0; i < NC; i++) begin
            if (core_start[i]) begin
               if (n_starts < 256) begin
                  log_core[n_starts] <= i;
                  log_key[n_starts]  <= int'(core_key[i*KW +: KW]);
                  log_cyc[n_starts]  <= cyc;
               end
               disp_cnt[core_key[i*KW +: KW]] <= disp_cnt[core_key[i*KW +: KW]] + 1;
               last_start_cyc <= cyc;
            end
            if (core_ack[i] && ckey[i] == 4'd9) last_ack9_cyc <= cyc;
         end
         n_starts <= n_starts + $countones(core_start);
         n_acks   <= n_acks + $countones(core_ack);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic start_sweep();
      search_start = 1'b1;
      tick(1);
      search_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!search_done && k < 500) begin
         tick(1);
         k++;
      end
      check({tag, "_done"}, search_done, 1);
      check({tag, "_busy"}, search_busy, 0);
   endtask

   task automatic release_core(input int i);
      int k = 0;
      hold[i] = 1'b0;
      while (!core_ack[i] && k < 40) begin
         tick(1);
         k++;
      end
      check($sformatf("ack%0d", i), core_ack[i], 1);
      hold[i] = 1'b1;
      tick(10);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},  search_busy, 0);
      check({tag, "_done"},  search_done, 0);
      check({tag, "_found"}, key_found, 0);
      check({tag, "_fkey"},  found_key, 0);
      check({tag, "_tried"}, keys_tried, 0);
      check({tag, "_start"}, core_start, 0);
      check({tag, "_ack"},   core_ack, 0);
      check({tag, "_key"},   core_key, 0);
   endtask

   initial begin
      int b, a, once;
      reset_n      = 1'b0;
      search_start = 1'b0;
      search_abort = 1'b0;
      hold         = '1;
      find_mask    = '0;
      lat          = 3;
      for (int k = 0; k < 16; k++) disp_cnt[k] = 0;
      #3;
      check_zero("rst");
      tick(2);
      reset_n = 1'b1;
      tick(2);

      // Exhaustive sweep, no finds
      hold = '0; lat = 5; find_mask = '0;
      b = n_starts;
      start_sweep();
      check("s1_busy", search_busy, 1);
      wait_done("s1");
      for (int i = 0; i < 4; i++) begin
         check($sformatf("s1_core%0d", i), log_core[b+i], i);
         check($sformatf("s1_key%0d", i), log_key[b+i], i);
         check($sformatf("s1_gap%0d", i), log_cyc[b+i] - log_cyc[b], i);
      end
      check("s1_found", key_found, 0);
      check("s1_fkey", found_key, 0);
      check("s1_tried", keys_tried, 16);
      once = 0;
      for (int k = 0; k < 16; k++) if (disp_cnt[k] == 1) once++;
      check("s1_once", once, 16);

      // Find on key 9, restarted from DONE
      find_mask = 16'h0200;
      b = n_starts; a = n_acks;
      start_sweep();
      check("s2_doneclr", search_done, 0);
      wait_done("s2");
      check("s2_found", key_found, 1);
      check("s2_fkey", found_key, 9);
      check("s2_tried", keys_tried, n_acks - a);
      check("s2_balance", n_starts - b, n_acks - a);
      check("s2_nodisp", last_start_cyc < last_ack9_cyc, 1);

      // Simultaneous finds on cores 1 (key 5) and 3 (key 7)
      hold = '1; lat = 3; find_mask = 16'h00A0;
      b = n_starts;
      start_sweep();
      tick(10);
      for (int i = 0; i < 4; i++) release_core(i);
      check("s3_starts8", n_starts - b, 8);
      check("s3_k5core", log_core[b+5], 1);
      begin
         int k = 0;
         hold[1] = 1'b0; hold[3] = 1'b0;
         while (core_ack == '0 && k < 40) begin tick(1); k++; end
         check("s3_ackpair", core_ack, 4'b1010);
         check("s3_found", key_found, 1);
         check("s3_fkey", found_key, 5);
         hold[1] = 1'b1; hold[3] = 1'b1;
      end
      release_core(0);
      release_core(2);
      wait_done("s3");
      check("s3_tried", keys_tried, 8);
      check("s3_starts", n_starts - b, 8);
      check("s3_fkeyend", found_key, 5);

      // Find on key 2, later find on key 4 during drain
      find_mask = 16'h0014;
      b = n_starts;
      start_sweep();
      tick(10);
      release_core(0);
      release_core(2);
      check("s4_found", key_found, 1);
      check("s4_fkey", found_key, 2);
      release_core(0);
      check("s4_fkeykeep", found_key, 2);
      release_core(1);
      release_core(3);
      wait_done("s4");
      check("s4_tried", keys_tried, 5);
      check("s4_starts", n_starts - b, 5);
      check("s4_fkeyend", found_key, 2);

      // Start pulse in RUN ignored, then reset mid-sweep
      find_mask = '0;
      b = n_starts;
      start_sweep();
      tick(10);
      start_sweep();
      check("s5_busy", search_busy, 1);
      release_core(0);
      check("s5_key4", log_key[b+4], 4);
      check("s5_tried", keys_tried, 1);
      reset_n = 1'b0;
      #1;
      check_zero("s5rst");
      tick(1);
      reset_n = 1'b1;
      tick(1);
      b = n_starts;
      start_sweep();
      tick(6);
      check("s5_rkey0", log_key[b], 0);
      check("s5_rcore0", log_core[b], 0);
      hold = '0;
      wait_done("s5");
      check("s5_tried16", keys_tried, 16);

`ifdef SCHED_ABORT_EN
      // Abort after six dispatches
      hold = '1; lat = 3; find_mask = '0;
      b = n_starts;
      start_sweep();
      tick(10);
      release_core(0);
      release_core(1);
      check("ab_starts6", n_starts - b, 6);
      search_abort = 1'b1;
      tick(1);
      search_abort = 1'b0;
      hold = '0;
      wait_done("ab");
      check("ab_starts", n_starts - b, 6);
      check("ab_tried", keys_tried, 6);
      check("ab_found", key_found, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
